fixed_to_float_conv: RTL and testbench
======================================

// Module: fixed_to_float_conv
// PURPOSE
//  Converts a 32-bit two's-complement fixed-point value into an IEEE-754 single-precision float.
//  It is the output-side counterpart of the float-to-fixed input normaliser: it takes the
//  fixed-point CORDIC/log datapath result back to float.
//  Start/ack handshake matches the input converter.
//  Normalisation is iterative: one left shift per cycle under FSM control.
// PARAMETERS
//  FRAC_BITS  26  number of fractional bits in FIXED; legal range 0..31
// PORTS
//  CLK           in   1   system clock; all state changes on rising edge
//  RST_FF        in   1   reset; synchronous, active-high
//  Begin_FSM_FF  in   1   start request; sampled only in IDLE
//  FIXED         in   32  signed fixed-point operand; sampled in LOAD
//  ACK_FF        out  1   one-cycle pulse, asserted while in DONE; RESULT valid from then on
//  BUSY          out  1   high in every state except IDLE
//  RESULT        out  32  IEEE-754 single; holds until the next PACK
// BEHAVIOUR
//  Reset
//   - RST_FF=1 at an edge: state<=IDLE, ACK_FF=0, BUSY=0, RESULT=32'h0, internal regs cleared.
//   - Reset overrides any operation in flight. No partial result is ever written.
//  FSM (one-hot or binary, encoding from package)
//   - IDLE: Begin_FSM_FF=1 -> LOAD; else stay.
//   - LOAD: sign<=FIXED[31]; mag<=sign ? -FIXED : FIXED (32-bit unsigned; 0x80000000 -> mag=2^31).
//     pos<=31. FIXED==0 -> PACK with zero flag set; else -> NORM.
//   - NORM: mag[31]==0 -> mag<=mag<<1, pos<=pos-1, stay; mag[31]==1 -> PACK.
//   - PACK: zero flag -> RESULT<=32'h0 (positive zero).
//     Else RESULT<={sign, 8'(127+pos-FRAC_BITS), mag[30:8]}; -> DONE.
//   - DONE: ACK_FF=1 for exactly this cycle; -> IDLE unconditionally.
//  Latency
//   - Start sampled at edge 0. ACK_FF is high in cycle 4+s, where s = 31-p and p = index of
//     the leading one of |FIXED|.
//   - Range: 4 cycles (p=31) to 35 cycles (p=0). Zero input gives ACK in cycle 3.
//  Arithmetic
//   - Mantissa is truncated (round toward zero); bits below mag[8] are discarded.
//   - Biased exponent = 127 + p - FRAC_BITS, always within 96..158 for the legal FRAC_BITS range.
//     No overflow, denormal, Inf or NaN path is required.
//  Boundary and concurrent cases
//   - Begin_FSM_FF while BUSY: ignored, not queued. Begin held high: a new conversion starts
//     on the cycle after DONE (back-to-back).
//   - FIXED may change after LOAD without effect.
//   - RESULT is stable from PACK until the next PACK, including across IDLE.
// STRUCTURE
//  Shared package/header
//   - FSM state encoding (IDLE, LOAD, NORM, PACK, DONE).
//   - IEEE constants: EXP_BIAS=127, MANT_W=23, EXP_W=8.
//  Sub-module fixed_norm_shifter
//   - Holds the mag and pos registers.
//   - Inputs: load, shift_en. Outputs: msb, mag, pos.
//  Top level: FSM, sign/zero flag registers, pack logic, RESULT register.
// TESTING  (FRAC_BITS=26 unless noted)
//  1. FIXED=0x04000000 (1.0) -> RESULT=0x3F800000; ACK_FF in cycle 9 (s=5).
//  2. FIXED=0xF6000000 (-2.5) -> RESULT=0xC0200000.
//     FIXED=0x80000000 (-32.0) -> RESULT=0xC2000000; ACK in cycle 4.
//  3. FIXED=0 -> RESULT=0x00000000, ACK in cycle 3.
//     FIXED=0x00000001 -> RESULT=0x32800000, ACK in cycle 35.
//  4. Truncation: FIXED=0x07FFFFFF -> RESULT=0x3FFFFFFF.
//  5. Handshake:
//     - Begin pulsed mid-conversion -> ignored, exactly one ACK.
//     - Begin held high -> ACK pulses back-to-back with one IDLE cycle between.
//  6. RST_FF in NORM -> next cycle IDLE, ACK_FF=0, RESULT=0.
//     A following conversion of 1.0 is still correct.

Source files
------------

// File: rtl/fixed_to_float_conv_pkg.sv
// Shared definitions for the fixed-point to IEEE-754 single converter:
// FSM state encoding and single-precision field constants.
package fixed_to_float_conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_NORM = 3'd2,
    ST_PACK = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 23;
  localparam int EXP_W    = 8;

endpackage

// File: rtl/fixed_to_float_conv_norm_shifter.sv
// Magnitude/leading-one position tracker: loads |FIXED| with pos=31, then
// shifts left one bit per enabled cycle until the MSB is set.
module fixed_to_float_conv_norm_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        shift_en,
  input  logic [31:0] value,
  output logic        msb,
  output logic [31:0] mag,
  output logic [4:0]  pos
);

  always_ff @(posedge clk) begin
    if (rst) begin
      mag <= 32'h0;
      pos <= 5'd0;
    end else if (load) begin
      mag <= value;
      pos <= 5'd31;
    end else if (shift_en) begin
      mag <= {mag[30:0], 1'b0};
      pos <= pos - 5'd1;
    end
  end

  assign msb = mag[31];

endmodule

// File: rtl/fixed_to_float_conv.sv
// Iterative signed fixed-point to IEEE-754 single converter: one normalising
// left shift per cycle, mantissa truncated, result held until the next pack.
module fixed_to_float_conv
  import fixed_to_float_conv_pkg::*;
#(
  parameter int FRAC_BITS = 26
) (
  input  logic        CLK,
  input  logic        RST_FF,
  input  logic        Begin_FSM_FF,
  input  logic [31:0] FIXED,
  output logic        ACK_FF,
  output logic        BUSY,
  output logic [31:0] RESULT,
  output state_t      state_dbg
);

  // Handshake: Begin_FSM_FF is only looked at in IDLE (never queued); ACK_FF
  // is a one-cycle pulse in DONE, and RESULT is valid from that cycle onward.
  state_t      state, state_next;
  logic        load, shift_en;
  logic        sign_q, zero_q;
  logic        msb;
  logic [31:0] mag;
  logic [4:0]  pos;
  logic [31:0] abs_value;
  logic [9:0]  exp_sum;
  logic [31:0] packed_value;
  logic        unused_mag_lsbs;

  // 0x80000000 negates to itself, which read unsigned is exactly 2^31.
  assign abs_value = FIXED[31] ? (~FIXED + 32'd1) : FIXED;

  fixed_to_float_conv_norm_shifter u_shifter (
    .clk      (CLK),
    .rst      (RST_FF),
    .load     (load),
    .shift_en (shift_en),
    .value    (abs_value),
    .msb      (msb),
    .mag      (mag),
    .pos      (pos)
  );

  always_ff @(posedge CLK) begin
    if (RST_FF) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    case (state)
      ST_IDLE: if (Begin_FSM_FF) state_next = ST_LOAD;
      ST_LOAD: begin
        load       = 1'b1;
        state_next = (FIXED == 32'h0) ? ST_PACK : ST_NORM;
      end
      ST_NORM: begin
        if (msb) state_next = ST_PACK;
        else     shift_en   = 1'b1;
      end
      ST_PACK: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST_FF) begin
      sign_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (state == ST_LOAD) begin
      sign_q <= FIXED[31];
      zero_q <= (FIXED == 32'h0);
    end
  end

  // The exponent always lands in 96..158, so the low 8 bits are exact.
  always_comb begin
    exp_sum      = 10'(EXP_BIAS) + 10'(pos) - 10'(FRAC_BITS);
    packed_value = {sign_q, exp_sum[EXP_W-1:0], mag[30 -: MANT_W]};
  end

  always_ff @(posedge CLK) begin
    if (RST_FF)                RESULT <= 32'h0;
    else if (state == ST_PACK) RESULT <= zero_q ? 32'h0 : packed_value;
  end

  assign unused_mag_lsbs = &{1'b0, mag[7:0]};

  assign ACK_FF    = (state == ST_DONE);
  assign BUSY      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_fixed_to_float_conv.sv
// Self-checking bench for fixed_to_float_conv: directed spec vectors, random
// operands against a reference model, handshake corner cases and mid-run reset.
module tb_fixed_to_float_conv;
  import fixed_to_float_conv_pkg::*;

  localparam int FRAC_BITS = 26;
  localparam int MAX_WAIT  = 60;

  logic        CLK = 1'b0;
  logic        RST_FF;
  logic        Begin_FSM_FF;
  logic [31:0] FIXED;
  logic        ACK_FF;
  logic        BUSY;
  logic [31:0] RESULT;
  state_t      state_dbg;

  logic [31:0] exp_q[$];
  int          exp_lat_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  fixed_to_float_conv #(.FRAC_BITS(FRAC_BITS)) dut (
    .CLK          (CLK),
    .RST_FF       (RST_FF),
    .Begin_FSM_FF (Begin_FSM_FF),
    .FIXED        (FIXED),
    .ACK_FF       (ACK_FF),
    .BUSY         (BUSY),
    .RESULT       (RESULT),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int lead_pos(input logic [31:0] m);
    int p;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    return p;
  endfunction

  function automatic logic [31:0] model_result(input logic [31:0] f);
    logic [31:0] m, n;
    int p;
    if (f == 32'h0) return 32'h0;
    m = f[31] ? (32'h0 - f) : f;
    p = lead_pos(m);
    n = m << (31 - p);
    return {f[31], 8'(127 + p - FRAC_BITS), n[30:8]};
  endfunction

  function automatic int model_latency(input logic [31:0] f);
    logic [31:0] m;
    if (f == 32'h0) return 3;
    m = f[31] ? (32'h0 - f) : f;
    return 4 + 31 - lead_pos(m);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic [31:0] v, input logic [31:0] exp_res, input int exp_lat);
    @(negedge CLK);
    Begin_FSM_FF = 1'b1;
    FIXED        = v;
    exp_q.push_back(exp_res);
    exp_lat_q.push_back(exp_lat);
    @(posedge CLK);
    #1 Begin_FSM_FF = 1'b0;
  endtask

  // Cycle n is the interval after edge n-1; FIXED is scrambled once LOAD has passed.
  task automatic wait_ack(output int lat, output bit timed_out);
    lat       = 0;
    timed_out = 1'b1;
    for (int n = 1; n <= MAX_WAIT; n++) begin
      @(negedge CLK);
      if (n == 2) FIXED = $urandom;
      if (ACK_FF === 1'b1) begin
        lat       = n;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_FF       = 1'b1;
    Begin_FSM_FF = 1'b0;
    FIXED        = 32'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (ACK_FF !== 1'b0 || BUSY !== 1'b0 || RESULT !== 32'h0 || state_dbg !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: ack=%b busy=%b result=%h state=%0d, required 0 0 00000000 IDLE",
               ACK_FF, BUSY, RESULT, state_dbg);
    end
    RST_FF = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] vin [6];
    logic [31:0] vres[6];
    int          vlat[6];
    logic [31:0] er, held;
    int          el, lat;
    bit          to;
    vin  = '{32'h04000000, 32'hF6000000, 32'h80000000, 32'h00000000, 32'h00000001, 32'h07FFFFFF};
    vres = '{32'h3F800000, 32'hC0200000, 32'hC2000000, 32'h00000000, 32'h32800000, 32'h3FFFFFFF};
    vlat = '{9, 8, 4, 3, 35, 9};
    for (int i = 0; i < 6; i++) begin
      drive_start(vin[i], vres[i], vlat[i]);
      wait_ack(lat, to);
      er = exp_q.pop_front();
      el = exp_lat_q.pop_front();
      n_checks++;
      if (to) begin
        n_fail++;
        $display("FAIL directed_timeout[%0d]: no ACK within %0d cycles, required ACK in cycle %0d", i, MAX_WAIT, el);
      end else begin
        if (RESULT !== er) begin
          n_fail++;
          $display("FAIL directed_result[%0d] in=%h: got %h, required %h", i, vin[i], RESULT, er);
        end
        n_checks++;
        if (lat != el) begin
          n_fail++;
          $display("FAIL directed_latency[%0d] in=%h: ACK in cycle %0d, required %0d", i, vin[i], lat, el);
        end
      end
      held = RESULT;
      @(negedge CLK);
      n_checks++;
      if (ACK_FF !== 1'b0 || BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_ack_pulse[%0d]: ack=%b busy=%b after DONE, required 0 0", i, ACK_FF, BUSY);
      end
      repeat (3) @(negedge CLK);
      n_checks++;
      if (RESULT !== held || RESULT !== er) begin
        n_fail++;
        $display("FAIL directed_hold[%0d]: RESULT %h in IDLE, required %h", i, RESULT, er);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] v, er;
    int          el, lat;
    bit          to;
    for (int i = 0; i < 12; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = 32'h0 - v;
      drive_start(v, model_result(v), model_latency(v));
      wait_ack(lat, to);
      er = exp_q.pop_front();
      el = exp_lat_q.pop_front();
      n_checks++;
      if (to || RESULT !== er || lat != el) begin
        n_fail++;
        $display("FAIL random[%0d] in=%h: result %h cycle %0d timeout %b, required %h cycle %0d",
                 i, v, RESULT, lat, to, er, el);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int acks, first_lat;
    drive_start(32'h00000001, 32'h32800000, 35);
    acks      = 0;
    first_lat = 0;
    for (int n = 1; n <= MAX_WAIT; n++) begin
      @(negedge CLK);
      if (n == 10) Begin_FSM_FF = 1'b1;
      if (n == 11) Begin_FSM_FF = 1'b0;
      if (ACK_FF === 1'b1) begin
        acks++;
        if (acks == 1) first_lat = n;
      end
    end
    n_checks++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL busy_ignore_count: %0d ACK pulses, required 1", acks);
    end
    n_checks++;
    if (first_lat != exp_lat_q.pop_front() || RESULT !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL busy_ignore_result: cycle %0d result %h, required cycle 35 result 32800000", first_lat, RESULT);
    end
  endtask

  task automatic test_back_to_back();
    int acks[$];
    logic [31:0] er;
    @(negedge CLK);
    Begin_FSM_FF = 1'b1;
    FIXED        = 32'h04000000;
    exp_q.push_back(32'h3F800000);
    exp_q.push_back(32'h3F800000);
    @(posedge CLK);
    for (int n = 1; n <= 30; n++) begin
      @(negedge CLK);
      if (n == 10) begin
        n_checks++;
        if (BUSY !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_idle_gap: BUSY=%b in cycle 10, required 0", BUSY);
        end
      end
      if (ACK_FF === 1'b1) begin
        acks.push_back(n);
        er = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        n_checks++;
        if (RESULT !== er) begin
          n_fail++;
          $display("FAIL b2b_result: got %h, required %h", RESULT, er);
        end
        if (acks.size() == 2) Begin_FSM_FF = 1'b0;
      end
    end
    Begin_FSM_FF = 1'b0;
    n_checks++;
    if (acks.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: %0d ACK pulses, required 2", acks.size());
    end else if (acks[0] != 9 || acks[1] != 19) begin
      n_fail++;
      $display("FAIL b2b_timing: ACK cycles %0d,%0d, required 9,19", acks[0], acks[1]);
    end
  endtask

  task automatic test_reset_mid();
    int  lat, spurious;
    bit  to;
    logic [31:0] er;
    drive_start(32'h04000000, 32'h3F800000, 9);
    wait_ack(lat, to);
    er = exp_q.pop_front();
    void'(exp_lat_q.pop_front());
    n_checks++;
    if (to || RESULT !== er) begin
      n_fail++;
      $display("FAIL rst_pre_result: result %h timeout %b, required %h", RESULT, to, er);
    end
    drive_start(32'h00000001, 32'h32800000, 35);
    repeat (5) @(negedge CLK);
    RST_FF = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (state_dbg !== ST_IDLE || ACK_FF !== 1'b0 || BUSY !== 1'b0 || RESULT !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_norm: state=%0d ack=%b busy=%b result=%h, required IDLE 0 0 00000000",
               state_dbg, ACK_FF, BUSY, RESULT);
    end
    RST_FF = 1'b0;
    exp_q.delete();
    exp_lat_q.delete();
    spurious = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (ACK_FF === 1'b1 || BUSY === 1'b1) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL rst_abort: %0d active cycles after reset, required 0", spurious);
    end
    drive_start(32'h04000000, 32'h3F800000, 9);
    wait_ack(lat, to);
    er = exp_q.pop_front();
    n_checks++;
    if (to || RESULT !== er || lat != exp_lat_q.pop_front()) begin
      n_fail++;
      $display("FAIL rst_post_result: result %h cycle %0d timeout %b, required %h cycle 9", RESULT, lat, to, er);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    repeat (3) @(negedge CLK);
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected results left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
